// File: rtl/pipeline_skid_register_pkg.sv
// rtl/pipeline_skid_register_pkg.sv - shared state encoding and width defaults for the skid register
package pipeline_skid_register_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occupancy_of(input state_t s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipeline_skid_register_ff.sv
// rtl/pipeline_skid_register_ff.sv - enable-gated data flip-flop with synchronous clear
module pipeline_skid_register_ff
    import pipeline_skid_register_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_skid_register.sv
// rtl/pipeline_skid_register.sv - two-entry elastic pipeline register with flush
module pipeline_skid_register
    import pipeline_skid_register_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    state_t       state;
    state_t       state_next;
    logic         accept;
    logic         consume;
    logic         main_we;
    logic         skid_we;
    logic [N-1:0] main_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) state_next = ONE;
            end
            ONE: begin
                if (accept && !consume) state_next = FULL;
                else if (!accept && consume) state_next = EMPTY;
            end
            FULL: begin
                if (consume) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // in_ready decodes only registered state, so it never follows out_ready
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        occupancy = occupancy_of(state);
        out_data  = main_q;
    end

    // Writes are suppressed under flush so a coincident accept leaves no trace
    always_comb begin
        main_we = 1'b0;
        skid_we = 1'b0;
        main_d  = in_data;
        if (!flush) begin
            case (state)
                EMPTY: main_we = accept;
                ONE: begin
                    main_we = accept & consume;
                    skid_we = accept & ~consume;
                end
                FULL: begin
                    main_we = consume;
                    main_d  = skid_q;
                end
                default: begin
                    main_we = 1'b0;
                    skid_we = 1'b0;
                end
            endcase
        end
    end

    pipeline_skid_register_ff #(.N(N)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_we),
        .d     (main_d),
        .q     (main_q)
    );

    pipeline_skid_register_ff #(.N(N)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_we),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipeline_skid_register.sv
// tb/tb_pipeline_skid_register.sv - self-checking bench for pipeline_skid_register
module tb_pipeline_skid_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_skid_register #(.N(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] d;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic        chk_d;
        logic [31:0] e_od;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [2:0] ctl, input logic [31:0] d, input logic ordy,
                                input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                                input logic chk_d, input logic [31:0] e_od);
        vec_t v;
        v.ctl = ctl; v.d = d; v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir;
        v.e_occ = e_occ; v.chk_d = chk_d; v.e_od = e_od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] q[$];
    logic        m_acc;
    logic        m_con;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // ctl = {reset, flush, in_valid}
        vecs[0]  = mk(3'b100, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0);
        vecs[1]  = mk(3'b001, 32'hAAAA5555, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'hAAAA5555);
        vecs[2]  = mk(3'b000, 32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
        vecs[3]  = mk(3'b001, 32'h1,        1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h1);
        vecs[4]  = mk(3'b001, 32'h2,        1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'h1);
        vecs[5]  = mk(3'b001, 32'h3,        1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'h1);
        vecs[6]  = mk(3'b001, 32'h3,        1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'h2);
        vecs[7]  = mk(3'b001, 32'h3,        1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'h3);
        vecs[8]  = mk(3'b000, 32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
        vecs[9]  = mk(3'b001, 32'h10,       1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h10);
        vecs[10] = mk(3'b001, 32'h11,       1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 32'h10);
        vecs[11] = mk(3'b011, 32'h12,       1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
        vecs[12] = mk(3'b000, 32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
        vecs[13] = mk(3'b001, 32'h20,       1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 32'h20);
        vecs[14] = mk(3'b111, 32'h21,       1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0);
        vecs[15] = mk(3'b000, 32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            {reset, flush, in_valid} = vecs[i].ctl;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            if (vecs[i].chk_d) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
        end
        reset = 1'b0; flush = 1'b0;

        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("thru%0d_out_data", i), out_data, 32'(i));
            chk($sformatf("thru%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("thru%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("thru_drained", 32'(out_valid), 32'd0);

        q.delete();
        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            flush     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            m_acc = in_valid && (q.size() < 2);
            m_con = (q.size() > 0) && out_ready;
            @(posedge clk); #1;
            if (reset || flush) begin
                q.delete();
            end else begin
                if (m_con) void'(q.pop_front());
                if (m_acc) q.push_back(in_data);
            end
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd_occupancy", 32'(occupancy), 32'(q.size()));
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) chk("rnd_out_data", out_data, q[0]);
            if (reset) chk("rnd_reset_out_data", out_data, 32'h0);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
